node_flit_tx: RTL and testbench

// - Clocked transmitter on the local core-to-node injection port. Accepts 4-bit payload + 4-bit

---
 rtl/node_flit_tx.sv | 152 +++++++++++++++
 tb/tb_node_flit_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_flit_tx.sv
// node_flit_tx: core-to-node injection transmitter.
// Takes a 4-bit payload and a 4-bit destination from the core and encodes the payload
// as Hamming(7,4). The result is queued in a small FIFO and sent as an 11-bit flit
// {dest, code} over a 4-phase bundled-data req/ack channel.
// Optional build macro: NODE_TX_ERR_INJECT_EN adds err_inj/err_pos, which flip one code
// bit at write time so the downstream corrector can be exercised.
//
// state  | meaning
// IDLE   | waiting for a queued flit; pops the FIFO head into out_data
// SETUP  | out_data settled, req still low (bundling margin)
// REQ_HI | req high, waiting for synchronized ack high
// REQ_LO | req low, waiting for synchronized ack low, then count completion
module node_flit_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] MY_ADDR    = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic [3:0]  in_dest,
  output logic        out_req,
  output logic [10:0] out_data,
  input  logic        out_ack,
  output logic [15:0] sent_cnt,
  output logic [7:0]  self_cnt,
  output logic        busy
`ifdef NODE_TX_ERR_INJECT_EN
  ,
  input  logic        err_inj,
  input  logic [2:0]  err_pos
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] REQ_HI = 2'd2;
  localparam logic [1:0] REQ_LO = 2'd3;

  logic [1:0]  state;
  logic        ack_meta;
  logic        ack_s;
  logic [10:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        wr_en;
  logic        rd_en;
  logic        p1;
  logic        p2;
  logic        p3;
  logic [6:0]  code;

  assign p1 = in_data[0] ^ in_data[1] ^ in_data[3];
  assign p2 = in_data[0] ^ in_data[2] ^ in_data[3];
  assign p3 = in_data[1] ^ in_data[2] ^ in_data[3];

  // Codeword for the payload currently offered, optionally with one bit flipped
  always_comb begin
    code = {in_data[3], in_data[2], in_data[1], p3, in_data[0], p2, p1};
`ifdef NODE_TX_ERR_INJECT_EN
    if (err_inj && (err_pos != 3'd7)) begin
      code = code ^ (7'd1 << err_pos);
    end
`endif
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready is held low while reset is asserted so nothing is captured in that window
  assign in_ready = rst_n && !full;
  assign wr_en    = in_valid && in_ready;
  assign rd_en    = (state == IDLE) && !empty;
  assign busy     = !empty || (state != IDLE);

  // Two-flop synchronizer for the asynchronous acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= out_ack;
      ack_s    <= ack_meta;
    end
  end

  // FIFO storage; needs no reset because the pointers define its contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {in_dest, code};
    end
  end

  // FIFO pointers, with an extra wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Handshake sequencer and completion counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
      sent_cnt <= '0;
      self_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en) begin
            out_data <= mem[rd_ptr[AW-1:0]];
            state    <= SETUP;
          end
        end
        SETUP: begin
          out_req <= 1'b1;
          state   <= REQ_HI;
        end
        REQ_HI: begin
          if (ack_s) begin
            out_req <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            sent_cnt <= sent_cnt + 16'd1;
            if (out_data[10:7] == MY_ADDR) begin
              self_cnt <= self_cnt + 8'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          out_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_flit_tx.sv
// Testbench for node_flit_tx: directed scenarios plus randomized traffic.
// Each expected flit comes from a Hamming position-layout model and is kept in order in a queue.
module tb_node_flit_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic [3:0]  in_dest = '0;
  logic        out_req;
  logic [10:0] out_data;
  logic        out_ack;
  logic [15:0] sent_cnt;
  logic [7:0]  self_cnt;
  logic        busy;

  logic        ack_auto = 1'b0;
  logic        ack_man = 1'b0;
  logic        ack_rsp = 1'b0;
  logic        prev_req = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  assign out_ack = ack_auto ? ack_rsp : ack_man;

  always #5 clk = ~clk;

`ifdef NODE_TX_ERR_INJECT_EN
  logic       err_inj = 1'b0;
  logic [2:0] err_pos = '0;
`endif

  node_flit_tx #(.FIFO_DEPTH(4), .MY_ADDR(4'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .sent_cnt (sent_cnt),
    .self_cnt (self_cnt),
    .busy     (busy)
`ifdef NODE_TX_ERR_INJECT_EN
    ,
    .err_inj  (err_inj),
    .err_pos  (err_pos)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hamming layout: positions 1,2,4 hold parity; 3,5,6,7 hold d0..d3.
  // Parity k covers every position whose index has bit k set.
  function automatic logic [10:0] model_flit(input logic [3:0] d, input logic [3:0] dst);
    logic [7:0] pos;
    logic       par;
    pos = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int j = 3; j < 8; j++) begin
        if (((j >> k) & 1) == 1 && j != 4) par = par ^ pos[j];
      end
      pos[1 << k] = par;
    end
    return {dst, pos[7:1]};
  endfunction

  // Receiver model: ack follows req after a random delay
  initial forever begin
    @(negedge clk);
    if (ack_auto) begin
      if (out_req && !ack_rsp) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ack_rsp = 1'b1;
      end else if (!out_req && ack_rsp) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ack_rsp = 1'b0;
      end
    end
  end

  // On every rising req, the offered flit must be the oldest one still expected
  always @(negedge clk) begin
    if (rst_n && out_req && !prev_req) begin
      if (exp_q.size() == 0) check("flit_unexpected", 32'd1, 32'd0);
      else check("flit_order", {21'd0, out_data}, {21'd0, exp_q.pop_front()});
    end
    prev_req = out_req;
  end

  task automatic send(input logic [3:0] d, input logic [3:0] dst);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (ok) exp_q.push_back(model_flit(d, dst));
    else check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_req(input logic lvl);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_req == lvl) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int nself;
    logic [3:0] d;
    logic [3:0] dst;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, out_req}, 32'd0);
    check("rst_data", {21'd0, out_data}, 32'd0);
    check("rst_sent", {16'd0, sent_cnt}, 32'd0);
    check("rst_self", {24'd0, self_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", {31'd0, in_ready}, 32'd1);

    // Single flit, manual handshake, exact latency
    send(4'b1011, 4'h3);
    check("t1_req_idle", {31'd0, out_req}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_data", {21'd0, out_data}, 32'h1D5);
    check("t1_req_setup", {31'd0, out_req}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_req_hi", {31'd0, out_req}, 32'd1);
    ack_man = 1'b1;
    wait_req(1'b0);
    ack_man = 1'b0;
    wait_idle(30);
    check("t1_sent", {16'd0, sent_cnt}, 32'd1);
    check("t1_self", {24'd0, self_cnt}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // Flit addressed to this node
    do_reset();
    send(4'hF, 4'h0);
    wait_req(1'b1);
    check("t2_data", {21'd0, out_data}, 32'h07F);
    ack_man = 1'b1;
    wait_req(1'b0);
    ack_man = 1'b0;
    wait_idle(30);
    check("t2_self", {24'd0, self_cnt}, 32'd1);
    check("t2_sent", {16'd0, sent_cnt}, 32'd1);

    // Back-pressure: ack held low, depth+1 writes fill the FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = 4'($urandom_range(0, 15));
      dst = 4'($urandom_range(0, 15));
      send(d, dst);
    end
    @(negedge clk);
    check("t3_ready_full", {31'd0, in_ready}, 32'd0);
    check("t3_req_stuck", {31'd0, out_req}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_sent_zero", {16'd0, sent_cnt}, 32'd0);
    ack_auto = 1'b1;
    wait_idle(500);
    ack_auto = 1'b0;
    check("t3_sent", {16'd0, sent_cnt}, 32'd5);
    check("t3_queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a handshake
    do_reset();
    send(4'h6, 4'h9);
    wait_req(1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_req_drop", {31'd0, out_req}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_sent", {16'd0, sent_cnt}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ack_man = 1'b1;
    repeat (6) @(negedge clk);
    ack_man = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_req_after", {31'd0, out_req}, 32'd0);
    check("t4_sent_after", {16'd0, sent_cnt}, 32'd0);
    check("t4_busy_after", {31'd0, busy}, 32'd0);

    // Random traffic with random gaps and random ack delays
    do_reset();
    ack_auto = 1'b1;
    n = 40;
    nself = 0;
    for (int i = 0; i < n; i++) begin
      d = 4'($urandom_range(0, 15));
      dst = 4'($urandom_range(0, 15));
      if (dst == 4'h0) nself++;
      send(d, dst);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_idle(3000);
    check("t5_sent", {16'd0, sent_cnt}, n);
    check("t5_self", {24'd0, self_cnt}, nself);
    check("t5_queue_drained", exp_q.size(), 32'd0);

    // self_cnt wrap after 256 self-addressed flits
    do_reset();
    for (int i = 0; i < 256; i++) begin
      d = 4'($urandom_range(0, 15));
      send(d, 4'h0);
      if (i == 254) begin
        wait_idle(200);
        check("t6_self_max", {24'd0, self_cnt}, 32'd255);
      end
    end
    wait_idle(500);
    ack_auto = 1'b0;
    check("t6_self_wrap", {24'd0, self_cnt}, 32'd0);
    check("t6_sent", {16'd0, sent_cnt}, 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
